// File: rtl/xpar_responder_pkg.sv
// ============================================================================
// Module : xpar_responder_pkg
// Brief  : Register offsets, STATUS/FLAGS bit positions and a STATUS packing
//          helper shared by the parallel-interface responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package xpar_responder_pkg;

  // Register map, selected by par_addr[1:0]
  typedef enum logic [1:0] {
    PAR_DATA    = 2'd0,
    PAR_STATUS  = 2'd1,
    PAR_FLAGS   = 2'd2,
    PAR_SCRATCH = 2'd3
  } par_reg_e;

  // STATUS bit and field positions
  localparam int c_ST_TX_FULL    = 0;
  localparam int c_ST_TX_EMPTY   = 1;
  localparam int c_ST_RX_FULL    = 2;
  localparam int c_ST_RX_EMPTY   = 3;
  localparam int c_ST_TX_CNT_LSB = 8;
  localparam int c_ST_RX_CNT_LSB = 16;

  // FLAGS bit positions
  localparam int c_FL_TX_OVF = 0;
  localparam int c_FL_RX_UDF = 1;

  // Assemble the 32-bit STATUS word; unlisted bits are zero.
  function automatic logic [31:0] pack_status(
    input logic       tx_full,
    input logic       tx_empty,
    input logic       rx_full,
    input logic       rx_empty,
    input logic [7:0] tx_cnt,
    input logic [7:0] rx_cnt
  );
    logic [31:0] v;
    v = '0;
    v[c_ST_TX_FULL]                      = tx_full;
    v[c_ST_TX_EMPTY]                     = tx_empty;
    v[c_ST_RX_FULL]                      = rx_full;
    v[c_ST_RX_EMPTY]                     = rx_empty;
    v[c_ST_TX_CNT_LSB +: 8]              = tx_cnt;
    v[c_ST_RX_CNT_LSB +: 8]              = rx_cnt;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xpar_fifo.sv
// ============================================================================
// Module : xpar_fifo
// Brief  : Synchronous FIFO with registered storage, count and a head output
//          that reads zero while empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module xpar_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  // Guard against overrun/underrun even if the caller does not.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  // Masking the head while empty keeps stale words off the outputs after reset.
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; no reset needed because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/xpar_responder.sv
// ============================================================================
// Module : xpar_responder
// Brief  : External responder on the CPU parallel interface. Decodes a
//          four-register map and bridges it to TX/RX valid-ready streams.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module xpar_responder
  import xpar_responder_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PAR_ADDR_W = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PAR_ADDR_W-1:0] par_addr,
  input  logic [DATA_W-1:0]     par_out,
  input  logic                  par_we,
  input  logic                  par_re,
  output logic [DATA_W-1:0]     par_in,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  par_reg_e          w_sel;
  logic              w_unused_addr;

  logic [DATA_W-1:0] w_tx_head;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic [CNT_W-1:0]  w_tx_count;
  logic              w_tx_push;
  logic              w_tx_pop;

  logic [DATA_W-1:0] w_rx_head;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic [CNT_W-1:0]  w_rx_count;
  logic              w_rx_push;
  logic              w_rx_pop;

  logic              w_data_wr;
  logic              w_data_rd;
  logic [1:0]        w_flag_set;
  logic [1:0]        w_flag_clr;

  logic [1:0]        r_flags;
  logic [DATA_W-1:0] r_scratch;

  assign w_sel         = par_reg_e'(par_addr[1:0]);
  assign w_unused_addr = ^par_addr[PAR_ADDR_W-1:2];

  // A simultaneous write wins: the read strobe then has no side effect.
  assign w_data_wr = par_we & (w_sel == PAR_DATA);
  assign w_data_rd = par_re & ~par_we & (w_sel == PAR_DATA);

  // Full/empty are pre-edge values, so a same-cycle stream pop cannot
  // rescue a write to a full TX FIFO.
  assign w_tx_push = w_data_wr & ~w_tx_full;
  assign w_tx_pop  = ~w_tx_empty & out_ready;
  assign w_rx_push = in_valid & ~w_rx_full;
  assign w_rx_pop  = w_data_rd & ~w_rx_empty;

  assign out_valid = ~w_tx_empty;
  assign out_data  = w_tx_head;
  assign in_ready  = ~w_rx_full;

  assign w_flag_set[c_FL_TX_OVF] = w_data_wr & w_tx_full;
  assign w_flag_set[c_FL_RX_UDF] = w_data_rd & w_rx_empty;
  assign w_flag_clr = (par_we && (w_sel == PAR_FLAGS)) ? par_out[1:0] : 2'b00;

  xpar_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .i_rst_n (rst),
    .i_push  (w_tx_push),
    .i_data  (par_out),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  xpar_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .i_rst_n (rst),
    .i_push  (w_rx_push),
    .i_data  (in_data),
    .i_pop   (w_rx_pop),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  // Sticky flags: write-1-to-clear, with a same-cycle set taking priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flags <= '0;
    end else begin
      r_flags <= (r_flags & ~w_flag_clr) | w_flag_set;
    end
  end

  // Scratch register for software use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scratch <= '0;
    end else if (par_we && (w_sel == PAR_SCRATCH)) begin
      r_scratch <= par_out;
    end
  end

  // Read-data mux; the RX head is already zero while RX is empty.
  always_comb begin
    par_in = '0;
    case (w_sel)
      PAR_DATA:    par_in = w_rx_head;
      PAR_STATUS:  par_in = DATA_W'(pack_status(w_tx_full, w_tx_empty,
                                                w_rx_full, w_rx_empty,
                                                8'(w_tx_count), 8'(w_rx_count)));
      PAR_FLAGS:   par_in = DATA_W'(r_flags);
      PAR_SCRATCH: par_in = r_scratch;
      default:     par_in = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_xpar_responder.sv
// ============================================================================
// Module : tb_xpar_responder
// Brief  : Directed self-checking bench with stream scoreboards.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xpar_responder;

  logic        clk;
  logic        rst;
  logic [14:0] par_addr;
  logic [31:0] par_out;
  logic        par_we;
  logic        par_re;
  logic [31:0] par_in;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  int          n_vec;
  int          n_bad;
  int          acc;
  logic [31:0] txq [$];
  logic [31:0] rxq [$];
  logic [31:0] exp_w;

  xpar_responder #(
    .DATA_W     (32),
    .PAR_ADDR_W (15),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .par_addr  (par_addr),
    .par_out   (par_out),
    .par_we    (par_we),
    .par_re    (par_re),
    .par_in    (par_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge with inputs set: scores handshakes, then advances one cycle.
  task automatic clk_step();
    #1;
    if (out_valid && out_ready) begin
      if (txq.size() == 0) begin
        check("tx_unexpected_word", out_data, 32'hFFFF_FFFF);
      end else begin
        exp_w = txq.pop_front();
        check("tx_stream", out_data, exp_w);
      end
    end
    if (in_valid && in_ready && rst) begin
      rxq.push_back(in_data);
      acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d, input logic re);
    par_addr = {13'b0, a};
    par_out  = d;
    par_we   = 1'b1;
    par_re   = re;
    clk_step();
    par_we   = 1'b0;
    par_re   = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [1:0] a, input logic [31:0] expv);
    par_addr = {13'b0, a};
    par_re   = 1'b1;
    #1;
    check(tag, par_in, expv);
    clk_step();
    par_re   = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; acc = 0;
    rst = 1'b0; par_addr = '0; par_out = '0; par_we = 1'b0; par_re = 1'b0;
    out_ready = 1'b0; in_data = '0; in_valid = 1'b0;

    // During reset
    @(negedge clk);
    par_addr = 15'h7FF1; // upper bits ignored, selects STATUS
    #1;
    check("rst_status", par_in, 32'h0000_000A);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // After reset
    cpu_read("status_after_rst", 2'd1, 32'h0000_000A);
    cpu_read("flags_after_rst", 2'd2, 32'h0);
    check("out_valid_after_rst", {31'b0, out_valid}, 32'd0);
    check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

    // Three writes, then drain
    cpu_write(2'd0, 32'h11, 1'b0); txq.push_back(32'h11);
    cpu_write(2'd0, 32'h22, 1'b0); txq.push_back(32'h22);
    cpu_write(2'd0, 32'h33, 1'b0); txq.push_back(32'h33);
    cpu_read("status_tx3", 2'd1, 32'h0000_0308);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("tx3_valid", {31'b0, out_valid}, 32'd1);
      clk_step();
    end
    check("tx3_drained_valid", {31'b0, out_valid}, 32'd0);
    check("tx3_sb_empty", txq.size(), 32'd0);

    // Fill TX, then overflow with a simultaneous stream pop
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cpu_write(2'd0, 32'h100 + i, 1'b0);
      txq.push_back(32'h100 + i);
    end
    cpu_read("status_tx_full", 2'd1, 32'h0000_0809);
    out_ready = 1'b1;
    cpu_write(2'd0, 32'hDEAD, 1'b0); // dropped: TX was full before the edge
    cpu_read("flags_ovf", 2'd2, 32'h1);
    for (int i = 0; i < 20 && out_valid; i++) clk_step();
    check("ovf_drain_done", {31'b0, out_valid}, 32'd0);
    check("ovf_sb_empty", txq.size(), 32'd0);
    cpu_write(2'd2, 32'h1, 1'b0);
    cpu_read("flags_cleared", 2'd2, 32'h0);
    out_ready = 1'b0;

    // RX fill from the producer
    in_valid = 1'b1;
    for (int i = 0; i < 20 && acc < 8; i++) begin
      in_data = 32'hA0 + acc;
      clk_step();
    end
    in_data = 32'hA8;
    #1;
    check("rx_accepts", acc, 32'd8);
    check("rx_in_ready_low", {31'b0, in_ready}, 32'd0);
    clk_step();
    in_valid = 1'b0;
    cpu_read("status_rx_full", 2'd1, 32'h0008_0006);
    for (int i = 0; i < 8; i++) begin
      exp_w = (rxq.size() != 0) ? rxq.pop_front() : 32'hFFFF_FFFF;
      cpu_read("rx_data", 2'd0, exp_w);
    end
    check("rx_in_ready_back", {31'b0, in_ready}, 32'd1);
    cpu_read("rx_underflow_data", 2'd0, 32'h0);
    cpu_read("flags_udf", 2'd2, 32'h2);
    cpu_write(2'd2, 32'h3, 1'b0);

    // Scratch
    cpu_write(2'd3, 32'hCAFE_F00D, 1'b0);
    cpu_read("scratch", 2'd3, 32'hCAFE_F00D);

    // Simultaneous write+read to DATA: write lands, no underflow
    cpu_write(2'd0, 32'h55, 1'b1); txq.push_back(32'h55);
    cpu_read("flags_we_re", 2'd2, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cpu_write(2'd0, 32'h60 + i, 1'b0);
      txq.push_back(32'h60 + i);
    end
    cpu_read("status_tx4", 2'd1, 32'h0000_0408);

    // Asynchronous reset mid-stream
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_data", out_data, 32'h0);
    txq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cpu_read("scratch_after_rst", 2'd3, 32'h0);
    cpu_read("status_after_rst2", 2'd1, 32'h0000_000A);
    cpu_read("flags_after_rst2", 2'd2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/xpar_responder.md
# xpar_responder

External-side responder for the CPU's parallel interface (`par_addr`, `par_out`, `par_we`, `par_re`, `par_in`). It sits outside the CPU subsystem, on the far side of the external window. It exposes a small register map to the CPU and bridges it to two valid/ready word streams:
- a TX FIFO, written by the CPU and drained by the downstream consumer;
- an RX FIFO, filled by the upstream producer and popped by the CPU.

## Interface
Parameters:
- `DATA_W`, 32: word width; equals `DATA_W` of the CPU data bus.
- `PAR_ADDR_W`, `ADDR_W-1`: width of `par_addr`.
- `FIFO_DEPTH`, 8: entries per FIFO; power of two, 2..128.

Ports:
- `clk` input 1: single clock; every register is in this domain.
- `rst` input 1: asynchronous, active-low reset.
- `par_addr` input `PAR_ADDR_W`: CPU address. Only `[1:0]` is decoded; upper bits are ignored.
- `par_out` input `DATA_W`: CPU write data.
- `par_we` input 1: CPU write strobe, one cycle per access.
- `par_re` input 1: CPU read strobe, one cycle per access.
- `par_in` output `DATA_W`: read data to the CPU; combinational from `par_addr` and registered state.
- `out_data` output `DATA_W`: TX FIFO head.
- `out_valid` output 1: TX FIFO not empty.
- `out_ready` input 1: consumer accepts the head.
- `in_data` input `DATA_W`: producer word.
- `in_valid` input 1: producer word is valid.
- `in_ready` output 1: RX FIFO not full.

## Operation
- Register map, selected by `par_addr[1:0]`:
  - 0 DATA: a write pushes `par_out` into TX. A read returns the RX head; `par_re` pops it.
  - 1 STATUS (read-only): bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, [15:8] tx_count, [23:16] rx_count, others 0. Writes are ignored.
  - 2 FLAGS: bit0 tx_overflow, bit1 rx_underflow. Sticky. Writing 1 to a bit clears it; writing 0 has no effect. Other bits read 0.
  - 3 SCRATCH: plain read/write `DATA_W` register.
- Write to DATA while TX is full: the word is dropped, tx_overflow is set, and the pointers are unchanged.
- Read of DATA while RX is empty: `par_in`=0, rx_underflow is set, and no pop occurs.
- Stream transfers:
  - TX pop on `out_valid & out_ready`.
  - RX push on `in_valid & in_ready`.
  - `in_ready` = !rx_full; `out_valid` = !tx_empty; `out_data` = TX head.
- Full and empty are evaluated from pre-edge state:
  - A CPU write to a full TX is dropped even if a stream pop happens in the same cycle.
  - An RX push to a full RX is impossible, because `in_ready` is low.
- Simultaneous push and pop on a non-full, non-empty FIFO: both take effect and the count is unchanged.
- `par_we` and `par_re` both high: the write takes effect; the read has no side effect (no pop, no underflow).
- Pointers wrap modulo `FIFO_DEPTH`. Count is held at `$clog2(FIFO_DEPTH)+1` bits and zero-extended into its 8-bit STATUS field.

## Timing
- Reset (`rst`=0, asynchronous) clears:
  - all pointers and counts;
  - FLAGS and SCRATCH to 0;
  - `out_valid`=0, `out_data`=0.

  `in_ready` is 1 during and after reset. `par_in` follows the decode: STATUS reads 0x0000_000A.
- Reset mid-operation discards all FIFO contents immediately. No handshake completes in the reset cycle.
- CPU write: takes effect at the edge where `par_we`=1; it is visible in STATUS in the next cycle.
- CPU read: `par_in` is valid in the same cycle as `par_re`. The pop occurs at that edge, so the next head appears in the following cycle.
- Stream latency: a word pushed at edge N is visible on `out_data`/`out_valid` after edge N (0-cycle fall-through is not supported). Throughput is one word per cycle per direction.
- FLAGS: set at the edge of the offending access. If a clear and a new set hit the same bit in the same cycle, the set wins.

## Structure
- Shared `xdefs.vh` additions:
  - register offsets `PAR_DATA`, `PAR_STATUS`, `PAR_FLAGS`, `PAR_SCRATCH`;
  - STATUS bit and field positions;
  - FLAGS bit positions.
- Sub-module `xpar_fifo`: a synchronous FIFO with `DATA_W` and `DEPTH` parameters. It provides push, pop, head, full, empty and count outputs, and is instantiated twice (TX and RX). The top level holds the decode, flags, scratch and stream glue.

## Test plan
- Reset, then read STATUS → 0x0000_000A; FLAGS → 0; `out_valid`=0; `in_ready`=1.
- Write 0x11, 0x22, 0x33 to DATA with `out_ready`=0. STATUS tx_count=3. Raise `out_ready` → `out_data` 0x11, 0x22, 0x33 on consecutive cycles, then `out_valid`=0.
- Fill TX with 8 words, then write 0xDEAD with `out_ready`=1 in the same cycle → word dropped, FLAGS=1. Drain yields the original 8 words. Write 1 to FLAGS → FLAGS=0.
- Drive `in_data` 0xA0..0xA7 with `in_valid`=1 held → `in_ready` falls after 8 accepts. Eight DATA reads return 0xA0..0xA7 in order. A ninth read returns 0 and sets FLAGS bit1.
- Write SCRATCH 0xCAFEF00D and read it back. Assert `rst`=0 mid-stream with TX holding 4 words → `out_valid` drops asynchronously; SCRATCH and counts read 0 after release.
